// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, flag indices and NV behaviour constants
package cond_pkg;

  localparam logic [3:0] EQ = 4'd0;
  localparam logic [3:0] NE = 4'd1;
  localparam logic [3:0] CS = 4'd2;
  localparam logic [3:0] CC = 4'd3;
  localparam logic [3:0] MI = 4'd4;
  localparam logic [3:0] PL = 4'd5;
  localparam logic [3:0] VS = 4'd6;
  localparam logic [3:0] VC = 4'd7;
  localparam logic [3:0] HI = 4'd8;
  localparam logic [3:0] LS = 4'd9;
  localparam logic [3:0] GE = 4'd10;
  localparam logic [3:0] LT = 4'd11;
  localparam logic [3:0] GT = 4'd12;
  localparam logic [3:0] LE = 4'd13;
  localparam logic [3:0] AL = 4'd14;
  localparam logic [3:0] NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic NV_ALWAYS = 1'b0;
  localparam logic NV_NEVER  = 1'b1;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator for one lane
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] i_nzcv,
  input  logic [3:0] i_cond,
  input  logic       i_nv_mode,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      EQ: o_pass = w_z;
      NE: o_pass = !w_z;
      CS: o_pass = w_c;
      CC: o_pass = !w_c;
      MI: o_pass = w_n;
      PL: o_pass = !w_n;
      VS: o_pass = w_v;
      VC: o_pass = !w_v;
      HI: o_pass = w_c & !w_z;
      // Full ARM LS; the old single-lane evaluator dropped the Z term
      LS: o_pass = !w_c | w_z;
      GE: o_pass = (w_n == w_v);
      LT: o_pass = (w_n != w_v);
      GT: o_pass = !w_z & (w_n == w_v);
      LE: o_pass = w_z | (w_n != w_v);
      AL: o_pass = 1'b1;
      NV: o_pass = (i_nv_mode == NV_NEVER) ? 1'b0 : 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_unit.sv
// rtl/cond_issue_unit.sv - multi-lane condition execution with chained NZCV flags
// Optional squash counter output enabled by COND_ISSUE_STATS_EN.
module cond_issue_unit
  import cond_pkg::*;
#(
  parameter int         LANES      = 2,
  parameter int         NV_MODE    = 0,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   in_lane_valid,
  input  logic [4*LANES-1:0] in_cond,
  input  logic [LANES-1:0]   in_setflags,
  input  logic [4*LANES-1:0] in_alu_nzcv,
  input  logic               flag_wr_en,
  input  logic [3:0]         flag_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_exec,
  output logic [3:0]         out_nzcv,
  output logic [3:0]         flags_o
`ifdef COND_ISSUE_STATS_EN
  ,
  output logic [31:0]        squash_cnt
`endif
);

  logic [3:0]       w_flags [LANES+1];
  logic [LANES-1:0] w_pass;
  logic [LANES-1:0] w_exec;
  logic             w_accept;
  logic             w_nv_mode;

  logic [3:0]       r_flags;
  logic             r_out_valid;
  logic [LANES-1:0] r_out_exec;
  logic [3:0]       r_out_nzcv;

  assign w_nv_mode = (NV_MODE != 0) ? NV_NEVER : NV_ALWAYS;

  // A direct flag write in the same cycle is visible to the bundle's oldest lane
  assign w_flags[0] = flag_wr_en ? flag_wr_data : r_flags;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    cond_eval u_eval (
      .i_nzcv   (w_flags[gi]),
      .i_cond   (in_cond[4*gi +: 4]),
      .i_nv_mode(w_nv_mode),
      .o_pass   (w_pass[gi])
    );
    assign w_exec[gi]    = in_lane_valid[gi] & w_pass[gi];
    assign w_flags[gi+1] = (w_exec[gi] & in_setflags[gi]) ? in_alu_nzcv[4*gi +: 4]
                                                          : w_flags[gi];
  end

  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= RESET_NZCV;
    end else if (w_accept) begin
      r_flags <= w_flags[LANES];
    end else if (flag_wr_en) begin
      r_flags <= flag_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_exec  <= '0;
      r_out_nzcv  <= 4'b0000;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_exec  <= w_exec;
      r_out_nzcv  <= w_flags[LANES];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_exec  = r_out_exec;
  assign out_nzcv  = r_out_nzcv;
  assign flags_o   = r_flags;

`ifdef COND_ISSUE_STATS_EN
  logic [31:0] w_squash_inc;
  logic [31:0] r_squash_cnt;

  always_comb begin
    w_squash_inc = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      w_squash_inc = w_squash_inc + 32'(in_lane_valid[i] & ~w_exec[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_squash_cnt <= 32'd0;
    end else if (w_accept) begin
      r_squash_cnt <= r_squash_cnt + w_squash_inc;
    end
  end

  assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_cond_issue_unit.sv
// tb/tb_cond_issue_unit.sv - randomized and directed bench for cond_issue_unit
module tb_cond_issue_unit;

  localparam int L = 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [L-1:0]   in_lane_valid;
  logic [4*L-1:0] in_cond;
  logic [L-1:0]   in_setflags;
  logic [4*L-1:0] in_alu_nzcv;
  logic           flag_wr_en;
  logic [3:0]     flag_wr_data;
  logic           out_ready;

  logic           in_ready  [2];
  logic           out_valid [2];
  logic [L-1:0]   out_exec  [2];
  logic [3:0]     out_nzcv  [2];
  logic [3:0]     flags_o   [2];
`ifdef COND_ISSUE_STATS_EN
  logic [31:0]    squash_cnt [2];
`endif

  int total = 0;
  int bad   = 0;
  bit started = 0;

  cond_issue_unit #(.LANES(L), .NV_MODE(0), .RESET_NZCV(4'b0000)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_lane_valid(in_lane_valid), .in_cond(in_cond), .in_setflags(in_setflags),
    .in_alu_nzcv(in_alu_nzcv), .flag_wr_en(flag_wr_en), .flag_wr_data(flag_wr_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_exec(out_exec[0]),
    .out_nzcv(out_nzcv[0]), .flags_o(flags_o[0])
`ifdef COND_ISSUE_STATS_EN
    , .squash_cnt(squash_cnt[0])
`endif
  );

  cond_issue_unit #(.LANES(L), .NV_MODE(1), .RESET_NZCV(4'b0000)) u_nv (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_lane_valid(in_lane_valid), .in_cond(in_cond), .in_setflags(in_setflags),
    .in_alu_nzcv(in_alu_nzcv), .flag_wr_en(flag_wr_en), .flag_wr_data(flag_wr_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_exec(out_exec[1]),
    .out_nzcv(out_nzcv[1]), .flags_o(flags_o[1])
`ifdef COND_ISSUE_STATS_EN
    , .squash_cnt(squash_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs: odd codes invert the even code's test.
  function automatic logic mpass(logic [3:0] f, logic [3:0] c, bit nv);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return !nv;
    case (c >> 1)
      0: b = z;
      1: b = cf;
      2: b = n;
      3: b = v;
      4: b = cf && !z;
      5: b = (n == v);
      default: b = !z && (n == v);
    endcase
    return c[0] ? !b : b;
  endfunction

  logic [3:0]   m_flags [2];
  logic         m_ov;
  logic [L-1:0] m_exec  [2];
  logic [3:0]   m_nzcv  [2];
  logic [31:0]  m_sq    [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ov = 0;
      for (int k = 0; k < 2; k++) begin
        m_flags[k] = 4'b0000; m_exec[k] = '0; m_nzcv[k] = 4'b0000; m_sq[k] = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && (!m_ov || out_ready);
      for (int k = 0; k < 2; k++) begin
        logic [3:0] f;
        logic [L-1:0] ex;
        int sq;
        f = flag_wr_en ? flag_wr_data : m_flags[k];
        ex = '0;
        sq = 0;
        for (int i = 0; i < L; i++) begin
          ex[i] = in_lane_valid[i] && mpass(f, in_cond[4*i +: 4], k == 1);
          if (in_lane_valid[i] && !ex[i]) sq++;
          if (ex[i] && in_setflags[i]) f = in_alu_nzcv[4*i +: 4];
        end
        if (acc) begin
          m_flags[k] = f; m_exec[k] = ex; m_nzcv[k] = f; m_sq[k] = m_sq[k] + 32'(sq);
        end else if (flag_wr_en) begin
          m_flags[k] = flag_wr_data;
        end
      end
      if (acc) m_ov = 1;
      else if (out_ready) m_ov = 0;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_ov));
        chk($sformatf("model in_ready[%0d]", k), 32'(in_ready[k]), 32'(!m_ov || out_ready));
        chk($sformatf("model out_exec[%0d]", k), 32'(out_exec[k]), 32'(m_exec[k]));
        chk($sformatf("model out_nzcv[%0d]", k), 32'(out_nzcv[k]), 32'(m_nzcv[k]));
        chk($sformatf("model flags_o[%0d]", k), 32'(flags_o[k]), 32'(m_flags[k]));
`ifdef COND_ISSUE_STATS_EN
        chk($sformatf("model squash_cnt[%0d]", k), squash_cnt[k], m_sq[k]);
`endif
      end
    end
  end

  task automatic setb(input logic v, input logic [L-1:0] lv, input logic [4*L-1:0] c,
                      input logic [L-1:0] sf, input logic [4*L-1:0] alu,
                      input logic wen, input logic [3:0] wd);
    in_valid = v; in_lane_valid = lv; in_cond = c; in_setflags = sf;
    in_alu_nzcv = alu; flag_wr_en = wen; flag_wr_data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    setb(0, '0, '0, '0, '0, 0, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1;
    chk("reset flags_o", 32'(flags_o[0]), 32'h0);
    chk("reset out_valid", 32'(out_valid[0]), 32'h0);
    chk("reset out_exec", 32'(out_exec[0]), 32'h0);

    // lane0 EQ, lane1 NE with clear flags
    setb(1, 2'b11, {4'd1, 4'd0}, 2'b00, 8'h00, 0, 4'b0000);
    step();
    chk("eqne out_valid", 32'(out_valid[0]), 32'h1);
    chk("eqne out_exec", 32'(out_exec[0]), 32'b10);
    chk("eqne out_nzcv", 32'(out_nzcv[0]), 32'b0000);

    // lane0 AL sets Z, lane1 EQ sees it
    setb(1, 2'b11, {4'd0, 4'd14}, 2'b01, {4'd0, 4'b0100}, 0, 4'b0000);
    step();
    chk("chain out_exec", 32'(out_exec[0]), 32'b11);
    chk("chain flags_o", 32'(flags_o[0]), 32'b0100);

    // failed setter leaves flags alone; flag write clears Z first
    setb(1, 2'b11, {4'd5, 4'd0}, 2'b01, {4'd0, 4'hf}, 1, 4'b0000);
    step();
    chk("failset out_exec", 32'(out_exec[0]), 32'b10);
    chk("failset flags_o", 32'(flags_o[0]), 32'b0000);

    out_ready = 1'b0;
    setb(1, 2'b11, {4'd14, 4'd14}, 2'b00, 8'h00, 0, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp in_ready", 32'(in_ready[0]), 32'h0);
      chk("bp out_exec", 32'(out_exec[0]), 32'b10);
      chk("bp out_valid", 32'(out_valid[0]), 32'h1);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 32'(in_ready[0]), 32'h1);
    step();
    chk("bp release out_exec", 32'(out_exec[0]), 32'b11);

    // write C then CS/CC bundle in the same cycle
    setb(1, 2'b11, {4'd3, 4'd2}, 2'b00, 8'h00, 1, 4'b0010);
    step();
    chk("wr+acc out_exec", 32'(out_exec[0]), 32'b01);
    chk("wr+acc flags_o", 32'(flags_o[0]), 32'b0010);

    // LS with C=1,Z=1 and cond 15 under both NV modes
    setb(1, 2'b11, {4'd15, 4'd9}, 2'b00, 8'h00, 1, 4'b0110);
    step();
    chk("ls/nv0 out_exec", 32'(out_exec[0]), 32'b11);
    chk("ls/nv1 out_exec", 32'(out_exec[1]), 32'b01);

    out_ready = 1'b0;
    setb(0, 2'b00, 8'h00, 2'b00, 8'h00, 1, 4'b0010);
    step();
    chk("wr flags_o", 32'(flags_o[0]), 32'b0010);
    chk("wr out_valid held", 32'(out_valid[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid[0]), 32'h0);
    chk("async rst flags_o", 32'(flags_o[0]), 32'h0);
    chk("async rst out_exec", 32'(out_exec[0]), 32'h0);
    setb(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 4'b0000);
    out_ready = 1'b1;
    step();
    rst = 1'b0;

`ifdef COND_ISSUE_STATS_EN
    for (int k = 0; k < 3; k++) begin
      setb(1, 2'b01, {4'd0, 4'd0}, 2'b00, 8'h00, 0, 4'b0000);
      step();
    end
    setb(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 4'b0000);
    chk("squash_cnt three", squash_cnt[0], 32'd3);
`endif

    // bubble: all lanes invalid, flags must survive
    setb(0, 2'b00, 8'h00, 2'b00, 8'h00, 1, 4'b1010);
    step();
    setb(1, 2'b00, {4'd14, 4'd14}, 2'b11, 8'hff, 0, 4'b0000);
    step();
    chk("bubble out_valid", 32'(out_valid[0]), 32'h1);
    chk("bubble out_exec", 32'(out_exec[0]), 32'b00);
    chk("bubble flags_o", 32'(flags_o[0]), 32'b1010);

    for (int n = 0; n < 600; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      setb(v, v ? L'($urandom) : '0, (4*L)'($urandom), L'($urandom), (4*L)'($urandom),
           ($urandom_range(0, 7) == 0), 4'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    setb(0, 2'b00, 8'h00, 2'b00, 8'h00, 0, 4'b0000);
    out_ready = 1'b1;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_issue_unit.md
Name: cond_issue_unit

Overview:
- Multi-lane condition-execution stage for the ARM7 core.
- Holds the architectural NZCV flag register and accepts a bundle of up to LANES instructions per cycle.
- Evaluates each lane's 4-bit condition code in program order, chaining flags set by earlier lanes into later lanes.
- Registers per-lane execute decisions toward writeback through a valid/ready output stage.

Parameters:
- LANES, 2, instructions per bundle (1..4); lane 0 is oldest.
- NV_MODE, 0, behaviour of cond 15: 0 = always execute, 1 = never execute (ARMv4 NV).
- RESET_NZCV, 4'b0000, flag register value after reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  bundle present.
- in_ready  out  1  unit can accept a bundle.
- in_lane_valid  in  LANES  per-lane occupancy; lane i valid only if bundle valid.
- in_cond  in  4*LANES  condition code of lane i in bits [4i+3:4i].
- in_setflags  in  LANES  lane i has S-bit set.
- in_alu_nzcv  in  4*LANES  flags produced by lane i's ALU result.
- flag_wr_en  in  1  MSR-style direct flag write.
- flag_wr_data  in  4  flag value for the direct write.
- out_valid  out  1  registered result valid.
- out_ready  in  1  downstream accepts result.
- out_exec  out  LANES  lane i executes (passed condition and was valid).
- out_nzcv  out  4  flags after the bundle.
- flags_o  out  4  current architectural flags register.

Behaviour:
- Flag bit order is N=3, Z=2, C=1, V=0.
- Condition table:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V). 14 AL: 1. 15: per NV_MODE.
- LS is !C|Z, the full ARM definition. This deliberately corrects the earlier single-lane evaluator.
- Start flags f0 = flag_wr_en ? flag_wr_data : flags register.
- For each lane i: exec_i = in_lane_valid[i] & pass(f_i, cond_i).
- Flag chaining: f_{i+1} = (exec_i & in_setflags[i]) ? alu_nzcv_i : f_i.
- Invalid and failed lanes never alter flags.
- Handshake: in_ready = !out_valid | out_ready. Accept = in_valid & in_ready.
- On accept, next edge:
  - flags register <= f_LANES;
  - out_exec <= exec vector; out_nzcv <= f_LANES;
  - out_valid <= 1.
- Latency is 1 cycle from accept to out_valid.
- Without accept: if out_ready, out_valid <= 0; otherwise outputs hold stable. out_exec and out_nzcv only change on accept.
- flag_wr_en without accept: flags register <= flag_wr_data.
- flag_wr_en with accept: the bundle evaluates against flag_wr_data, and the final value is f_LANES.
- in_valid with all lane_valid bits 0: accepted, out_exec = 0, flags unchanged (bubble passes through).
- Back-to-back bundles: bundle k+1 sees flags written by bundle k, since the flag register updates on the accept edge.
- Reset, asynchronous and mid-operation included:
  - flags = RESET_NZCV, out_valid = 0, out_exec = 0, out_nzcv = 0;
  - any in-flight result is discarded.
- flags_o always mirrors the flag register.

Optional Feature:
- Macro COND_ISSUE_STATS_EN.
- When defined, adds output squash_cnt [31:0]. It increments by the number of lanes with in_lane_valid=1 and exec=0 on each accept. It wraps modulo 2^32 and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package cond_pkg holds:
  - condition-code localparams EQ..NV (0..15);
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - NV_ALWAYS/NV_NEVER constants.
- One natural sub-module, cond_eval: combinational (nzcv, cond, nv_mode) -> pass. It is instantiated LANES times in a generate loop, chained by the flag-propagation logic in cond_issue_unit.

Test Plan:
- Reset with RESET_NZCV=4'b0000, then a bundle with lane0 EQ, lane1 NE, both valid -> out_exec=2'b10, out_nzcv=0000 one cycle later.
- Intra-bundle chaining: flags 0000; lane0 AL with setflags, alu=0100; lane1 EQ -> out_exec=2'b11, flags_o=0100.
- Failed setter: flags 0000; lane0 EQ with setflags, alu=1111; lane1 PL -> out_exec=2'b10, flags remain 0000.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_exec/out_nzcv stable for 3 cycles; out_ready=1 -> the next bundle is accepted the same cycle.
- Flag write plus accept: flag_wr_en with data 0010 and a bundle with lane0 CS -> exec lane0=1.
- Flag write plus reset: flag_wr_en with data 0010, then rst pulsed while out_valid=1 -> out_valid=0 and flags_o=RESET_NZCV immediately.
- NV_MODE=1, cond 15 -> exec=0; NV_MODE=0 -> exec=1. LS with C=1, Z=1 -> exec=1.
- With COND_ISSUE_STATS_EN: 3 bundles each with one failing valid lane -> squash_cnt=3.
